// File: rtl/lock_status_decoder_pkg.sv
// lock_pkg: shared lock state codes and 7-segment glyphs for the lock FSM and its status decoder.
package lock_pkg;
  localparam logic [2:0] IDLE           = 3'd0;
  localparam logic [2:0] SET_AWAITING   = 3'd1;
  localparam logic [2:0] OPENED         = 3'd2;
  localparam logic [2:0] ALARM          = 3'd3;
  localparam logic [2:0] INPUT_PASSWORD = 3'd4;
  localparam logic [7:0] SEG_IDLE  = 8'h40;
  localparam logic [7:0] SEG_SET   = 8'h6D;
  localparam logic [7:0] SEG_OPEN  = 8'h3F;
  localparam logic [7:0] SEG_ALARM = 8'h77;
  localparam logic [7:0] SEG_INPUT = 8'h73;
  localparam logic [7:0] SEG_ERR   = 8'h79;
  function automatic logic [7:0] glyph(input logic [2:0] c);
    return c == IDLE           ? SEG_IDLE  :
           c == SET_AWAITING   ? SEG_SET   :
           c == OPENED         ? SEG_OPEN  :
           c == ALARM          ? SEG_ALARM :
           c == INPUT_PASSWORD ? SEG_INPUT : SEG_ERR;
  endfunction
endpackage

// File: rtl/lock_status_decoder_code_sync_filter.sv
// code_sync_filter: two-flop synchronizer plus stability filter; a code is accepted after holding STABLE_CYCLES+1 sync cycles.
module code_sync_filter
  import lock_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] state_in,
  output logic [2:0] cur_code
);
  localparam logic [3:0] SC    = 4'(STABLE_CYCLES);
  localparam logic [3:0] SC_M1 = 4'(STABLE_CYCLES - 1);
  logic [2:0] sync1_q, sync2_q, cand_q, cur_q, cur_d;
  logic [3:0] stab_q, stab_d;
  always_comb begin
    stab_d = (sync2_q != cand_q) ? 4'd0 : (stab_q == SC) ? stab_q : stab_q + 4'd1;
    cur_d  = (sync2_q == cand_q && stab_q == SC_M1) ? cand_q : cur_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
      cand_q  <= IDLE;
      cur_q   <= IDLE;
      stab_q  <= 4'd0;
    end else begin
      sync1_q <= state_in;
      sync2_q <= sync1_q;
      cand_q  <= sync2_q;
      cur_q   <= cur_d;
      stab_q  <= stab_d;
    end
  end
  assign cur_code = cur_q;
endmodule

// File: rtl/lock_status_decoder.sv
// lock_status_decoder: decodes the filtered lock state into a 7-segment glyph, LEDs and a failed-attempt counter.
// Define ALARM_LATCH_EN to keep alarm_led set after ALARM until an accepted OPENED.
module lock_status_decoder
  import lock_pkg::*;
#(
  parameter int BLINK_DIV     = 100,
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] state_in,
  output logic [7:0] seg_out,
  output logic       opened_led,
  output logic       alarm_led,
  output logic [2:0] fail_count,
  output logic       code_err
);
  localparam logic [15:0] BD_M1 = 16'(BLINK_DIV - 1);
  logic [2:0]  cur_code, prev_q, fail_q, fail_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  seg_q, seg_d;
  logic        phase_q, phase_d, opened_q, opened_d, alarm_q, alarm_d, err_q, err_d;
  logic        changed, enter_alarm, from_input, wrap;
  code_sync_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .state_in (state_in),
    .cur_code (cur_code)
  );
  always_comb begin
    changed     = cur_code != prev_q;
    enter_alarm = changed && cur_code == ALARM;
    from_input  = changed && prev_q == INPUT_PASSWORD;
    wrap        = cnt_q == BD_M1;
    cnt_d       = (enter_alarm || wrap) ? 16'd0 : cnt_q + 16'd1;
    phase_d     = enter_alarm ? 1'b1 : wrap ? ~phase_q : phase_q;
    fail_d      = (from_input && cur_code == ALARM && fail_q != 3'd7) ? fail_q + 3'd1 :
                  (from_input && cur_code == OPENED) ? 3'd0 : fail_q;
    // using next-cycle phase/fail keeps the first ALARM frame lit and dp in step with fail_count
    seg_d       = ((cur_code == ALARM && !phase_d) ? 8'h00 : glyph(cur_code)) | {fail_d != 3'd0, 7'h00};
    opened_d    = cur_code == OPENED;
    err_d       = cur_code > INPUT_PASSWORD;
`ifdef ALARM_LATCH_EN
    alarm_d     = cur_code == ALARM ? 1'b1 : cur_code == OPENED ? 1'b0 : alarm_q;
`else
    alarm_d     = cur_code == ALARM;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= IDLE;
      cnt_q    <= 16'd0;
      phase_q  <= 1'b1;
      fail_q   <= 3'd0;
      seg_q    <= SEG_IDLE;
      opened_q <= 1'b0;
      alarm_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_q   <= cur_code;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      fail_q   <= fail_d;
      seg_q    <= seg_d;
      opened_q <= opened_d;
      alarm_q  <= alarm_d;
      err_q    <= err_d;
    end
  end
  assign seg_out    = seg_q;
  assign opened_led = opened_q;
  assign alarm_led  = alarm_q;
  assign fail_count = fail_q;
  assign code_err   = err_q;
endmodule

// File: tb/tb_lock_status_decoder.sv
// tb_lock_status_decoder: directed and random state streams checked against a behavioural model of the decoder.
module tb_lock_status_decoder;
  localparam int SC = 2;
  localparam int BD = 100;
`ifdef ALARM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] state_in = 3'd0;
  logic [7:0] seg_out;
  logic       opened_led, alarm_led, code_err;
  logic [2:0] fail_count;
  int checks = 0;
  int failures = 0;
  lock_status_decoder #(.BLINK_DIV(BD), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state_in   (state_in),
    .seg_out    (seg_out),
    .opened_led (opened_led),
    .alarm_led  (alarm_led),
    .fail_count (fail_count),
    .code_err   (code_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [7:0] gl [8] = '{8'h40, 8'h6D, 8'h3F, 8'h77, 8'h73, 8'h79, 8'h79, 8'h79};
  logic [2:0] hist [$];
  logic [2:0] m_cur, m_prev;
  int         k, alarm_start, m_fail;
  logic       m_alarm, m_open, m_err;
  logic [7:0] m_seg;
  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < SC + 3; i++) hist.push_back(3'd0);
    m_cur = 0; m_prev = 0; k = 0; alarm_start = 0; m_fail = 0;
    m_alarm = 0; m_open = 0; m_err = 0; m_seg = 8'h40;
  endfunction
  function automatic void model_step(input logic [2:0] v);
    bit same;
    k++;
    if (m_cur != m_prev) begin
      if (m_prev == 3'd4 && m_cur == 3'd3 && m_fail < 7) m_fail++;
      if (m_prev == 3'd4 && m_cur == 3'd2) m_fail = 0;
      if (m_cur == 3'd3) alarm_start = k;
    end
    m_seg = (m_cur == 3'd3 && ((k - alarm_start) / BD) % 2 == 1) ? 8'h00 : gl[m_cur];
    m_seg[7] = m_fail != 0;
    m_open = m_cur == 3'd2;
    m_err = m_cur > 3'd4;
    if (LATCH) m_alarm = (m_cur == 3'd3) ? 1'b1 : (m_cur == 3'd2) ? 1'b0 : m_alarm;
    else m_alarm = m_cur == 3'd3;
    m_prev = m_cur;
    // accept a code once STABLE_CYCLES+1 consecutive sync2 samples agree
    hist.push_back(v);
    void'(hist.pop_front());
    same = 1;
    for (int i = 1; i <= SC; i++) if (hist[i] != hist[0]) same = 0;
    if (same) m_cur = hist[0];
  endfunction
  task automatic tick(input logic [2:0] v);
    state_in = v;
    @(posedge clk);
    model_step(v);
    @(negedge clk);
    check("outs", 32'({seg_out, opened_led, alarm_led, code_err, fail_count}),
          32'({m_seg, m_open, m_alarm, m_err, 3'(m_fail)}));
  endtask
  task automatic run(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg_out), 32'h40);
    check("rst_flags", 32'({opened_led, alarm_led, code_err, fail_count}), 32'd0);
    rst_n = 1'b1;
    run(3'd0, 10);
    check("idle_seg", 32'(seg_out), 32'h40);
    for (int i = 1; i <= 6; i++) begin
      tick(3'd2);
      if (i == 5) check("lat_early", 32'(opened_led), 32'd0);
      if (i == 6) check("lat_open", 32'({opened_led, seg_out}), 32'h13F);
    end
    run(3'd2, 4);
    run(3'd0, 8);
    tick(3'd4);
    run(3'd0, 10);
    check("glitch", 32'(seg_out), 32'h40);
    for (int r = 1; r <= 3; r++) begin
      run(3'd4, 8);
      run(3'd3, 8);
      check("fail_cnt", 32'(fail_count), 32'(r));
      check("fail_dp", 32'(seg_out[7]), 32'd1);
      run(3'd0, 8);
    end
    for (int r = 0; r < 6; r++) begin
      run(3'd4, 8);
      run(3'd3, 8);
      run(3'd0, 8);
    end
    check("fail_sat", 32'(fail_count), 32'd7);
    run(3'd4, 8);
    run(3'd2, 8);
    check("fail_clr", 32'({seg_out[7], fail_count}), 32'd0);
    run(3'd0, 8);
    for (int i = 1; i <= 455; i++) begin
      tick(3'd3);
      if (i == 6 || i == 105 || i == 206) check("blink_on", 32'(seg_out[6:0]), 32'h77);
      if (i == 106 || i == 205) check("blink_off", 32'(seg_out[6:0]), 32'h00);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 32'({seg_out, opened_led, alarm_led, code_err, fail_count}), 32'h40 << 6);
    model_reset();
    @(posedge clk);
    #1 check("rst_hold", 32'({seg_out, alarm_led}), 32'h80);
    @(negedge clk);
    rst_n = 1'b1;
    run(3'd3, 10);
    run(3'd0, 10);
    check("latch_hold", 32'(alarm_led), 32'(LATCH));
    run(3'd4, 10);
    run(3'd2, 10);
    check("latch_clr", 32'(alarm_led), 32'd0);
    run(3'd6, 10);
    check("err_flag", 32'({code_err, seg_out}), 32'h179);
    run(3'd0, 10);
    for (int n = 0; n < 1200; n++) begin
      logic [2:0] v;
      int sel;
      sel = int'($urandom_range(0, 9));
      v = sel < 3 ? 3'd4 : sel < 5 ? 3'd3 : sel < 6 ? 3'd2 : 3'($urandom_range(0, 7));
      run(v, int'($urandom_range(1, 6)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
